// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: fetch PC, single-entry IF/ID output buffer, branch redirect.
// Optional HALT opcode detection is enabled by defining FETCH_HALT_DETECT_EN.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] pc_out,
    output logic [15:0] pc_inc,
    output logic [15:0] instr,
    output logic        if_valid,
    output logic        ifid_wen,
    output logic        halted
);

`ifdef FETCH_HALT_DETECT_EN
    localparam logic HALT_DETECT = 1'b1;
`else
    localparam logic HALT_DETECT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] fpc_q, fpc_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] pc_inc_q, pc_inc_d;
    logic [15:0] instr_q, instr_d;
    logic        if_valid_q, if_valid_d;
    logic        halted_q, halted_d;

    logic        consume;
    logic        fetch_done;
    logic        halt_hit;

    // A request is only issued when the buffer is empty or drains this cycle,
    // and never in a cycle that is being redirected.
    assign imem_req   = rst && (state_q == S_FETCH) && (!if_valid_q || !stall) && !branch_taken;
    assign imem_addr  = fpc_q;
    assign ifid_wen   = if_valid_q && !stall;
    assign consume    = if_valid_q && !stall;
    assign fetch_done = imem_req && imem_ready;
    assign halt_hit   = HALT_DETECT && (imem_rdata[15:12] == HALT_OPCODE);

    assign pc_out   = pc_out_q;
    assign pc_inc   = pc_inc_q;
    assign instr    = instr_q;
    assign if_valid = if_valid_q;
    assign halted   = halted_q;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        fpc_d      = fpc_q;
        pc_out_d   = pc_out_q;
        pc_inc_d   = pc_inc_q;
        instr_d    = instr_q;
        if_valid_d = if_valid_q;
        halted_d   = halted_q;

        if (branch_taken) begin
            fpc_d      = branch_target;
            if_valid_d = 1'b0;
            halted_d   = 1'b0;
            state_d    = S_FETCH;
        end else begin
            if (fetch_done) begin
                pc_out_d   = fpc_q;
                pc_inc_d   = fpc_q + 16'd2;
                instr_d    = imem_rdata;
                if_valid_d = 1'b1;
                if (halt_hit) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    fpc_d = fpc_q + 16'd2;
                end
            end else if (consume) begin
                if_valid_d = 1'b0;
            end

            if (state_q == S_IDLE) begin
                state_d = S_FETCH;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the combinational block above uses blocking.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fpc_q      <= RESET_PC;
            pc_out_q   <= 16'h0000;
            pc_inc_q   <= 16'h0000;
            instr_q    <= 16'h0000;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            pc_out_q   <= pc_out_d;
            pc_inc_q   <= pc_inc_d;
            instr_q    <= instr_d;
            if_valid_q <= if_valid_d;
            halted_q   <= halted_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios plus randomized traffic
// compared against a transaction-level fetch model kept in the bench.
module tb_if_fetch_stage;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_ready = 1'b0;
    logic [15:0] pc_out, pc_inc, instr;
    logic        if_valid, ifid_wen, halted;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [15:0] m_fpc = 16'h0000;
    logic [15:0] m_pc = 16'h0000, m_inc = 16'h0000, m_instr = 16'h0000;
    bit          m_valid = 0, m_halted = 0, m_started = 0;
    bit          e_req = 0;

    if_fetch_stage #(.RESET_PC(16'h0000), .HALT_OPCODE(4'hF)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc_out(pc_out),
        .pc_inc(pc_inc), .instr(instr), .if_valid(if_valid), .ifid_wen(ifid_wen),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Apply inputs for one cycle and derive the request the model expects.
    task automatic set_inputs(input bit r, input bit s, input bit b, input logic [15:0] t,
                              input bit rdy, input logic [15:0] data);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        imem_ready = rdy; imem_rdata = data;
        e_req = r && m_started && !m_halted && (!m_valid || !s) && !b;
        #1;
    endtask

    // Advance one clock edge and apply the fetch rules to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            m_fpc = 16'h0000; m_pc = 16'h0000; m_inc = 16'h0000; m_instr = 16'h0000;
            m_valid = 0; m_halted = 0; m_started = 0;
        end else if (branch_taken) begin
            m_fpc = branch_target; m_valid = 0; m_halted = 0; m_started = 1;
        end else begin
            if (e_req && imem_ready) begin
                m_pc = m_fpc; m_inc = m_fpc + 16'd2; m_instr = imem_rdata; m_valid = 1;
                if (HALT_EN && imem_rdata[15:12] == 4'hF) m_halted = 1;
                else m_fpc = m_fpc + 16'd2;
            end else if (m_valid && !stall) begin
                m_valid = 0;
            end
            m_started = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        set_inputs(0, 1, 1, 16'h1234, 1, 16'h5555);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", imem_req); end
        tick();
        n_tests++; if (pc_out !== 16'h0 || pc_inc !== 16'h0 || instr !== 16'h0) begin
            n_fail++; $display("FAIL reset_buf got %h/%h/%h exp 0/0/0", pc_out, pc_inc, instr); end
        n_tests++; if (if_valid !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got v=%b h=%b exp 0/0", if_valid, halted); end
        set_inputs(0, 0, 0, 16'h0, 1, 16'h0);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req2 got %b exp 0", imem_req); end
        tick();
        set_inputs(1, 0, 0, 16'h0, 1, 16'h0);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req got %b exp 0", imem_req); end
        tick();
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 4; k++) begin
            logic [15:0] a;
            a = 16'(2 * k);
            set_inputs(1, 0, 0, 16'h0, 1, 16'hA000 + 16'(k));
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== a) begin
                n_fail++; $display("FAIL seq_addr%0d got req=%b addr=%h exp 1/%h", k, imem_req, imem_addr, a); end
            n_tests++; if (ifid_wen !== (k > 0)) begin
                n_fail++; $display("FAIL seq_wen%0d got %b exp %b", k, ifid_wen, (k > 0)); end
            tick();
            n_tests++; if (pc_out !== a || pc_inc !== a + 16'd2 || instr !== 16'hA000 + 16'(k) || if_valid !== 1'b1) begin
                n_fail++; $display("FAIL seq_buf%0d got %h/%h/%h v=%b exp %h/%h/%h v=1",
                                   k, pc_out, pc_inc, instr, if_valid, a, a + 16'd2, 16'hA000 + 16'(k)); end
        end
    endtask

    task automatic test_wait();
        set_inputs(1, 0, 1, 16'h0010, 1, 16'hDEAD);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL wait_brreq got %b exp 0", imem_req); end
        tick();
        for (int k = 0; k < 3; k++) begin
            set_inputs(1, 0, 0, 16'h0, 0, 16'hDEAD);
            n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
                n_fail++; $display("FAIL wait_hold%0d got req=%b addr=%h exp 1/0010", k, imem_req, imem_addr); end
            tick();
            n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid%0d got %b exp 0", k, if_valid); end
        end
        set_inputs(1, 0, 0, 16'h0, 1, 16'h1234);
        tick();
        n_tests++; if (pc_out !== 16'h0010 || pc_inc !== 16'h0012 || instr !== 16'h1234 || if_valid !== 1'b1) begin
            n_fail++; $display("FAIL wait_done got %h/%h/%h v=%b exp 0010/0012/1234 v=1", pc_out, pc_inc, instr, if_valid); end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 2; k++) begin
            set_inputs(1, 1, 0, 16'h0, 1, 16'h7777);
            n_tests++; if (imem_req !== 1'b0 || ifid_wen !== 1'b0) begin
                n_fail++; $display("FAIL stall_out%0d got req=%b wen=%b exp 0/0", k, imem_req, ifid_wen); end
            tick();
            n_tests++; if (pc_out !== 16'h0010 || instr !== 16'h1234 || if_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold%0d got %h/%h v=%b exp 0010/1234 v=1", k, pc_out, instr, if_valid); end
        end
        set_inputs(1, 0, 0, 16'h0, 1, 16'h2345);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0012 || ifid_wen !== 1'b1) begin
            n_fail++; $display("FAIL stall_resume got req=%b addr=%h wen=%b exp 1/0012/1", imem_req, imem_addr, ifid_wen); end
        tick();
        n_tests++; if (pc_out !== 16'h0012 || instr !== 16'h2345) begin
            n_fail++; $display("FAIL stall_next got %h/%h exp 0012/2345", pc_out, instr); end
    endtask

    task automatic test_branch_priority();
        set_inputs(1, 1, 1, 16'h0100, 1, 16'hBEEF);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL br_req got %b exp 0", imem_req); end
        tick();
        n_tests++; if (if_valid !== 1'b0 || instr === 16'hBEEF) begin
            n_fail++; $display("FAIL br_drop got v=%b instr=%h exp v=0 instr!=beef", if_valid, instr); end
        set_inputs(1, 0, 0, 16'h0, 0, 16'h0);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
            n_fail++; $display("FAIL br_target got req=%b addr=%h exp 1/0100", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_wrap();
        set_inputs(1, 0, 1, 16'hFFFE, 0, 16'h0);
        tick();
        set_inputs(1, 0, 0, 16'h0, 1, 16'h4321);
        n_tests++; if (imem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr got %h exp fffe", imem_addr); end
        tick();
        n_tests++; if (pc_out !== 16'hFFFE || pc_inc !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_inc got %h/%h exp fffe/0000", pc_out, pc_inc); end
        set_inputs(1, 0, 0, 16'h0, 0, 16'h0);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            n_fail++; $display("FAIL wrap_next got req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
        tick();
        set_inputs(1, 0, 1, 16'h0333, 0, 16'h0);
        tick();
        set_inputs(1, 0, 0, 16'h0, 0, 16'h0);
        n_tests++; if (imem_addr !== 16'h0333) begin n_fail++; $display("FAIL odd_target got %h exp 0333", imem_addr); end
        tick();
    endtask

    task automatic test_halt();
        set_inputs(1, 0, 1, 16'h0020, 0, 16'h0);
        tick();
        set_inputs(1, 0, 0, 16'h0, 1, 16'hF000);
        n_tests++; if (imem_addr !== 16'h0020) begin n_fail++; $display("FAIL halt_addr got %h exp 0020", imem_addr); end
        tick();
        n_tests++; if (if_valid !== 1'b1 || pc_out !== 16'h0020 || instr !== 16'hF000 || halted !== HALT_EN) begin
            n_fail++; $display("FAIL halt_buf got v=%b %h/%h h=%b exp v=1 0020/f000 h=%b",
                               if_valid, pc_out, instr, halted, HALT_EN); end
        set_inputs(1, 0, 0, 16'h0, 1, 16'h1111);
`ifdef FETCH_HALT_DETECT_EN
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_noreq got %b exp 0", imem_req); end
        tick();
        set_inputs(1, 0, 0, 16'h0, 1, 16'h1111);
        n_tests++; if (imem_req !== 1'b0 || halted !== 1'b1) begin
            n_fail++; $display("FAIL halt_stay got req=%b h=%b exp 0/1", imem_req, halted); end
        tick();
`else
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0022) begin
            n_fail++; $display("FAIL nohalt_next got req=%b addr=%h exp 1/0022", imem_req, imem_addr); end
        tick();
`endif
        set_inputs(1, 1, 1, 16'h0040, 1, 16'hF000);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_brreq got %b exp 0", imem_req); end
        tick();
        n_tests++; if (halted !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_clear got h=%b v=%b exp 0/0", halted, if_valid); end
        set_inputs(1, 0, 0, 16'h0, 0, 16'h0);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            n_fail++; $display("FAIL halt_resume got req=%b addr=%h exp 1/0040", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_reset_mid_request();
        set_inputs(0, 0, 0, 16'h0, 1, 16'hAAAA);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req got %b exp 0", imem_req); end
        tick();
        n_tests++; if (if_valid !== 1'b0 || instr !== 16'h0) begin
            n_fail++; $display("FAIL midrst_buf got v=%b instr=%h exp 0/0000", if_valid, instr); end
        set_inputs(1, 0, 0, 16'h0, 1, 16'hAAAA);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst_idle got %b exp 0", imem_req); end
        tick();
        n_tests++; if (if_valid !== 1'b0 || instr !== 16'h0) begin
            n_fail++; $display("FAIL midrst_stale got v=%b instr=%h exp 0/0000", if_valid, instr); end
        set_inputs(1, 0, 0, 16'h0, 0, 16'h0);
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            n_fail++; $display("FAIL midrst_first got req=%b addr=%h exp 1/0000", imem_req, imem_addr); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            bit          r, s, b, rdy;
            logic [15:0] t, d;
            r   = ($urandom_range(0, 99) >= 2);
            s   = ($urandom_range(0, 99) < 30);
            b   = ($urandom_range(0, 99) < 8);
            rdy = ($urandom_range(0, 99) < 65);
            t   = 16'($urandom);
            d   = 16'($urandom);
            set_inputs(r, s, b, t, rdy, d);
            n_tests++; if (imem_req !== e_req || ifid_wen !== (m_valid && s)) begin
                if (imem_req !== e_req || ifid_wen !== (m_valid && !s)) begin
                    n_fail++; $display("FAIL rnd_ctl%0d got req=%b wen=%b exp %b/%b", c, imem_req, ifid_wen, e_req, m_valid && !s);
                end
            end
            if (e_req) begin
                n_tests++; if (imem_addr !== m_fpc) begin
                    n_fail++; $display("FAIL rnd_addr%0d got %h exp %h", c, imem_addr, m_fpc); end
            end
            tick();
            n_tests++; if (if_valid !== m_valid || halted !== m_halted) begin
                n_fail++; $display("FAIL rnd_flags%0d got v=%b h=%b exp %b/%b", c, if_valid, halted, m_valid, m_halted); end
            n_tests++; if (pc_out !== m_pc || pc_inc !== m_inc || instr !== m_instr) begin
                n_fail++; $display("FAIL rnd_buf%0d got %h/%h/%h exp %h/%h/%h", c, pc_out, pc_inc, instr, m_pc, m_inc, m_instr); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_sequential();
        test_wait();
        test_stall();
        test_branch_priority();
        test_wrap();
        test_halt();
        test_reset_mid_request();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
